// File: rtl/pov_slice_scheduler_if.sv
// Bundle of the hall sensor input, the strip-controller handshake and the status outputs
// of the POV slice scheduler. The scheduler uses the master side.
interface pov_slice_scheduler_if #(
  parameter int SLICE_WIDTH  = 6,
  parameter int PERIOD_WIDTH = 28
);
  logic                    hall_in;
  logic                    busy;
  logic                    start;
  logic [SLICE_WIDTH-1:0]  slice_idx;
  logic                    locked;
  logic [PERIOD_WIDTH-1:0] period;
  logic [7:0]              overrun_count;

  modport master (
    input  hall_in, busy,
    output start, slice_idx, locked, period, overrun_count
  );

  modport slave (
    output hall_in, busy,
    input  start, slice_idx, locked, period, overrun_count
  );
endinterface

// File: rtl/pov_slice_scheduler.sv
// Measures the rotor period from the once-per-revolution hall mark and issues one strip
// frame start per angular slice, tagged with the slice index to render.
module pov_slice_scheduler #(
  parameter int SLICES       = 64,
  parameter int SLICE_WIDTH  = 6,
  parameter int PERIOD_WIDTH = 28,
  parameter int MIN_PERIOD   = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  pov_slice_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  localparam logic [PERIOD_WIDTH-1:0] REV_MAX   = '1;
  localparam logic [PERIOD_WIDTH-1:0] P_ONE     = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH:0]   P_ONE_EXT = (PERIOD_WIDTH+1)'(1);
  localparam logic [PERIOD_WIDTH:0]   MIN_EXT   = (PERIOD_WIDTH+1)'(MIN_PERIOD);
  localparam logic [SLICE_WIDTH-1:0]  LAST_SLICE = SLICE_WIDTH'(SLICES-1);
  localparam logic [SLICE_WIDTH-1:0]  S_ONE      = SLICE_WIDTH'(1);

  state_t state, state_next;

  logic                    hall_s1, hall_s2, hall_prev;
  logic [PERIOD_WIDTH-1:0] rev_cnt;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PERIOD_WIDTH-1:0] slice_timer;
  logic [SLICE_WIDTH-1:0]  slice_num;
  logic [SLICE_WIDTH-1:0]  slice_idx_q;
  logic                    start_q;
  logic                    locked_q;
  logic [7:0]              overrun_q;

  logic                    hall_edge, edge_ok, edge_acc, rev_sat, wrap;
  logic [PERIOD_WIDTH:0]   rev_plus1;
  logic [PERIOD_WIDTH-1:0] period_meas;
  logic [PERIOD_WIDTH-1:0] slice_len;
  logic                    boundary;
  logic [SLICE_WIDTH-1:0]  boundary_slice;

  assign hall_edge   = hall_s2 & ~hall_prev;
  assign rev_plus1   = {1'b0, rev_cnt} + P_ONE_EXT;
  assign rev_sat     = (rev_cnt == REV_MAX);
  assign edge_ok     = (state == IDLE) || (rev_plus1 >= MIN_EXT);
  assign edge_acc    = hall_edge & edge_ok;
  assign period_meas = rev_sat ? REV_MAX : rev_plus1[PERIOD_WIDTH-1:0];
  assign slice_len   = period_q >> SLICE_WIDTH;
  // The last slice of a revolution never wraps; only the next hall mark restarts at slice 0.
  assign wrap = (state == RUN) && (slice_num != LAST_SLICE) &&
                (slice_timer == slice_len - P_ONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (hall_edge) state_next = SYNC;
      SYNC: if (edge_acc) state_next = RUN;
            else if (rev_sat) state_next = IDLE;
      RUN:  if (edge_acc) state_next = RUN;
            else if (rev_sat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // An accepted mark beats a coincident timer wrap so only slice 0 is issued.
  always_comb begin
    boundary       = 1'b0;
    boundary_slice = slice_num;
    if (edge_acc && (state != IDLE)) begin
      boundary       = 1'b1;
      boundary_slice = '0;
    end else if (wrap) begin
      boundary       = 1'b1;
      boundary_slice = slice_num + S_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hall_s1     <= 1'b1;
      hall_s2     <= 1'b1;
      hall_prev   <= 1'b1;
      rev_cnt     <= '0;
      period_q    <= '0;
      slice_timer <= '0;
      slice_num   <= '0;
      slice_idx_q <= '0;
      start_q     <= 1'b0;
      locked_q    <= 1'b0;
      overrun_q   <= 8'd0;
    end else begin
      hall_s1   <= bus.hall_in;
      hall_s2   <= hall_s1;
      hall_prev <= hall_s2;

      if (edge_acc)      rev_cnt <= '0;
      else if (!rev_sat) rev_cnt <= rev_cnt + P_ONE;

      if (edge_acc && (state != IDLE)) period_q <= period_meas;

      if (edge_acc || wrap) slice_timer <= '0;
      else if ((state == RUN) && (slice_num != LAST_SLICE)) slice_timer <= slice_timer + P_ONE;

      if (boundary) slice_num <= boundary_slice;

      start_q <= boundary & ~bus.busy;
      if (boundary && !bus.busy) slice_idx_q <= boundary_slice;
      if (boundary && bus.busy && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'd1;

      locked_q <= (state_next == RUN);
    end
  end

  assign bus.start         = start_q;
  assign bus.slice_idx     = slice_idx_q;
  assign bus.locked        = locked_q;
  assign bus.period        = period_q;
  assign bus.overrun_count = overrun_q;

endmodule

// File: tb/tb_pov_slice_scheduler.sv
// Directed timeline bench for pov_slice_scheduler with a 4-slice, 12-bit-period configuration.
module tb_pov_slice_scheduler;

  logic clk = 1'b0;
  logic rst;

  pov_slice_scheduler_if #(.SLICE_WIDTH(2), .PERIOD_WIDTH(12)) bus ();

  pov_slice_scheduler #(
    .SLICES(4), .SLICE_WIDTH(2), .PERIOD_WIDTH(12), .MIN_PERIOD(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    bit         hall;
    bit         busy;
    bit         start;
    logic [1:0] slice;
    bit         locked;
    logic [11:0] period;
    logic [7:0] ovr;
    int         starts;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   failures = 0;
  int   now = 0;
  int   start_cnt = 0;
  bit   prev_start = 1'b0;

  function automatic void addVec(int t, bit h, bit b, bit s, int sl, bit lk, int per, int ov, int st);
    vec_t v;
    v.t = t; v.hall = h; v.busy = b; v.start = s; v.slice = 2'(sl);
    v.locked = lk; v.period = 12'(per); v.ovr = 8'(ov); v.starts = st;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit hall, input bit busy);
    bus.hall_in = hall;
    bus.busy    = busy;
  endtask

  // One cycle: sample on the falling edge and keep a running count of frame starts.
  task automatic tick();
    @(negedge clk);
    now++;
    if (bus.start === 1'b1) begin
      start_cnt++;
      checkOutput($sformatf("t%0d_start_not_back_to_back", now), int'(prev_start), 0);
    end
    prev_start = (bus.start === 1'b1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_start"},     int'(bus.start), 0);
    checkOutput({tag, "_slice_idx"}, int'(bus.slice_idx), 0);
    checkOutput({tag, "_locked"},    int'(bus.locked), 0);
    checkOutput({tag, "_period"},    int'(bus.period), 0);
    checkOutput({tag, "_overrun"},   int'(bus.overrun_count), 0);
  endtask

  initial begin
    // Relative timeline: a rising hall_in driven at t shows its start at t+3.
    addVec(   0,0,0, 0,0,0,  0,0, 0);
    addVec(  10,1,0, 0,0,0,  0,0, 0);
    addVec(  20,0,0, 0,0,0,  0,0, 0);
    addVec( 410,1,0, 0,0,0,  0,0, 0);
    addVec( 412,1,0, 0,0,0,  0,0, 0);
    addVec( 413,1,0, 1,0,1,400,0, 1);
    addVec( 414,1,0, 0,0,1,400,0, 1);
    addVec( 420,0,0, 0,0,1,400,0, 1);
    addVec( 512,0,0, 0,0,1,400,0, 1);
    addVec( 513,0,0, 1,1,1,400,0, 2);
    addVec( 613,0,0, 1,2,1,400,0, 3);
    addVec( 713,0,0, 1,3,1,400,0, 4);
    addVec( 810,1,0, 0,3,1,400,0, 4);
    addVec( 812,0,0, 0,3,1,400,0, 4);
    addVec( 813,0,0, 1,0,1,400,0, 5);
    addVec( 815,1,0, 0,0,1,400,0, 5);
    addVec( 820,0,0, 0,0,1,400,0, 5);
    addVec( 825,0,0, 0,0,1,400,0, 5);
    addVec( 913,0,0, 1,1,1,400,0, 6);
    addVec(1000,0,1, 0,1,1,400,0, 6);
    addVec(1013,0,1, 0,1,1,400,1, 6);
    addVec(1020,0,0, 0,1,1,400,1, 6);
    addVec(1113,0,0, 1,3,1,400,1, 7);
    addVec(1210,1,0, 0,3,1,400,1, 7);
    addVec(1213,1,0, 1,0,1,400,1, 8);
    addVec(1220,0,0, 0,0,1,400,1, 8);
    addVec(1313,0,0, 1,1,1,400,1, 9);
    addVec(1413,0,0, 1,2,1,400,1,10);
    addVec(1510,1,0, 0,2,1,400,1,10);
    addVec(1513,1,0, 1,0,1,300,1,11);
    addVec(1514,1,0, 0,0,1,300,1,11);
    addVec(1520,0,0, 0,0,1,300,1,11);
    addVec(1587,0,0, 0,0,1,300,1,11);
    addVec(1588,0,0, 1,1,1,300,1,12);
    addVec(1663,0,0, 1,2,1,300,1,13);
    addVec(1738,0,0, 1,3,1,300,1,14);
    addVec(1810,1,0, 0,3,1,300,1,14);
    addVec(1813,1,0, 1,0,1,300,1,15);
    addVec(1820,0,0, 0,0,1,300,1,15);
    addVec(1888,0,0, 1,1,1,300,1,16);
    addVec(1963,0,0, 1,2,1,300,1,17);
    addVec(2035,1,0, 0,2,1,300,1,17);
    addVec(2038,1,0, 1,0,1,225,1,18);
    addVec(2039,1,0, 0,0,1,225,1,18);
    addVec(2045,0,0, 0,0,1,225,1,18);
    addVec(2094,0,0, 1,1,1,225,1,19);
    addVec(2150,0,0, 1,2,1,225,1,20);
    addVec(2206,0,0, 1,3,1,225,1,21);
    addVec(6133,0,0, 0,3,1,225,1,21);
    addVec(6134,0,0, 0,3,0,225,1,21);
    addVec(6310,1,0, 0,3,0,225,1,21);
    addVec(6320,0,0, 0,3,0,225,1,21);
    addVec(6710,1,0, 0,3,0,225,1,21);
    addVec(6713,1,0, 1,0,1,400,1,22);
    addVec(6720,0,0, 0,0,1,400,1,22);

    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkAllZero("reset");
    repeat (100) tick();
    checkOutput("reset_no_start_hall_high", start_cnt, 0);
    checkOutput("reset_still_unlocked", int'(bus.locked), 0);

    now = 0;
    foreach (vecs[i]) begin
      while (now < vecs[i].t) tick();
      checkOutput($sformatf("t%0d_start", now),     int'(bus.start), int'(vecs[i].start));
      checkOutput($sformatf("t%0d_slice_idx", now), int'(bus.slice_idx), int'(vecs[i].slice));
      checkOutput($sformatf("t%0d_locked", now),    int'(bus.locked), int'(vecs[i].locked));
      checkOutput($sformatf("t%0d_period", now),    int'(bus.period), int'(vecs[i].period));
      checkOutput($sformatf("t%0d_overrun", now),   int'(bus.overrun_count), int'(vecs[i].ovr));
      checkOutput($sformatf("t%0d_start_count", now), start_cnt, vecs[i].starts);
      applyStimulus(vecs[i].hall, vecs[i].busy);
    end

    // Reset while tracking must drop everything back to reset values on the next cycle.
    while (now < 6750) tick();
    rst = 1'b1;
    tick();
    checkAllZero("midrun_reset");
    rst = 1'b0;
    repeat (200) tick();
    checkOutput("midrun_reset_no_start", start_cnt, 22);
    checkOutput("midrun_reset_unlocked", int'(bus.locked), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/pov_slice_scheduler.md
# pov_slice_scheduler

Rotation-synchronised scheduler for the persistence-of-vision LED strip. It measures the rotor period from a once-per-revolution hall sensor pulse and divides each revolution into `SLICES` equal angular slices. At each slice boundary it issues a one-cycle `start` to the strip controller, together with the slice index the pattern source must render. It sits between the hall sensor pin and the strip's `start` input, replacing the constant `start` tie-off.

## Interface
- `SLICES`, 64, angular slices per revolution; must equal 2**`SLICE_WIDTH`
- `SLICE_WIDTH`, 6, width of slice index
- `PERIOD_WIDTH`, 28, width of period counter; all-ones value is the stall timeout
- `MIN_PERIOD`, 1_000_000, shortest accepted edge spacing in cycles (debounce); must be >= `SLICES`
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `hall_in`  in  1  raw hall sensor, asynchronous, rising edge = index mark
- `busy`  in  1  strip controller still shifting previous frame
- `start`  out  1  one-cycle pulse: begin strip frame
- `slice_idx`  out  SLICE_WIDTH  slice being rendered; valid from `start` until next `start`
- `locked`  out  1  period measured and tracking
- `period`  out  PERIOD_WIDTH  last accepted revolution period in cycles
- `overrun_count`  out  8  saturating count of slice boundaries skipped because `busy`

## Operation
- `hall_in` passes through a 2-FF synchroniser, then a previous-sample register. Edge = sync2 & ~prev. Synchroniser and prev reset to 1, so a sensor held high through reset yields no edge.
- `rev_cnt` resets to 0 on each accepted edge and increments every cycle. It saturates at all-ones.
- An edge is accepted iff state is IDLE, or `rev_cnt`+1 >= `MIN_PERIOD`. Rejected edges have no effect on any register.
- On an accepted edge (not in IDLE): `period` <= `rev_cnt`+1.
  - `slice_len` = new `period` >> `SLICE_WIDTH` (floor). It is used from the same cycle.
- States:
  - IDLE: `locked`=0, no `start`. Any edge -> SYNC; `rev_cnt` cleared.
  - SYNC: first mark seen, measuring. Accepted edge -> RUN: latch `period`, `locked`<=1, slice boundary for slice 0. `rev_cnt` saturating -> IDLE.
  - RUN: `slice_timer` counts 0..`slice_len`-1; wrapping marks a boundary for the next slice.
    - Slice number saturates at `SLICES`-1: no wrap, and no extra boundaries, until the next edge.
    - Accepted edge forces slice 0, clears `slice_timer`, and updates `period`/`slice_len`.
    - `rev_cnt` saturating -> IDLE, `locked`<=0, `period` holds last value.
- Slice boundary handling:
  - If `busy`=0: `start`=1 for one cycle and `slice_idx` <= slice number.
  - If `busy`=1: no `start`, `slice_idx` holds, and `overrun_count` increments (saturating at 255). The internal slice number still advances.
- Accepted edge coincident with a timer wrap: the edge wins and exactly one boundary (slice 0) occurs.
- `rst` mid-operation: everything returns to reset values next cycle, state IDLE.

## Timing
- Reset values: `start`=0, `slice_idx`=0, `locked`=0, `period`=0, `overrun_count`=0, state IDLE, counters 0.
- Latency: `hall_in` first sampled high at clock edge k -> edge detected at k+2 -> registered `start` high during cycle k+3 (slice 0, RUN).
- In RUN, consecutive boundaries are exactly `slice_len` cycles apart. Slice s boundary is at edge_cycle + s*`slice_len`.
- `start` is registered, never high two consecutive cycles. `slice_idx` changes only in the cycle `start` is high.
- Timeout: IDLE entered the cycle after `rev_cnt` reaches 2**`PERIOD_WIDTH`-1.

## Test plan
Parameters for all scenarios: `SLICES`=4, `SLICE_WIDTH`=2, `PERIOD_WIDTH`=12, `MIN_PERIOD`=16.

- Reset: assert `rst` with `hall_in` high, release -> all outputs 0, no `start` for 100 cycles with `hall_in` held high.
- Lock: rising edges 400 cycles apart.
  - First edge -> no `start`.
  - Second edge -> `start` 3 cycles after sampling, `period`=400, `locked`=1, `slice_idx`=0.
  - Further `start`s 100, 200, 300 cycles later with `slice_idx` 1, 2, 3. No fourth before the next edge.
- Debounce: in RUN, extra rising edge 5 cycles after an accepted edge -> ignored; `period` unchanged, no extra `start`.
- Overrun: hold `busy`=1 across the slice-2 boundary.
  - No `start` there; `slice_idx` stays 1; `overrun_count`=1.
  - Slice-3 `start` still at +300 with `slice_idx`=3.
- Period change: edge spacing drops to 300 -> `period`=300, `start`s 75 cycles apart. Edge landing on a slice wrap produces a single `start` with `slice_idx`=0.
- Stall: stop edges -> `locked`=0 the cycle after `rev_cnt` hits 4095, no further `start`. Next two edges relock.
